// File: rtl/maq_pkg.sv
// Shared types and default timing constants for the digital clock controller.
package maq_pkg;

    typedef enum logic [1:0] {
        MODO_RUN      = 2'd0,
        MODO_SET_HORA = 2'd1,
        MODO_SET_MIN  = 2'd2
    } modo_t;

    localparam int CLK_FREQ_DEFAULT  = 50_000_000;
    localparam int BLINK_DIV_DEFAULT = 12_500_000;

endpackage

// File: rtl/maq_botao.sv
// Push-button front end: two-flop synchronizer followed by a rising-edge detector.
module maq_botao (
    input  logic clock,
    input  logic reset,
    input  logic nivel,
    output logic pulso
);

    logic sync_p0, sync_p1, sync_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= nivel;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // sync_p2 is sync_p1 one cycle late, so a held level yields a single pulse.
    assign pulso = sync_p1 & ~sync_p2;

endmodule

// File: rtl/maq_ctrl.sv
// Timebase, carry chaining and RUN/SET_HORA/SET_MIN mode control for the digital clock.
module maq_ctrl
    import maq_pkg::*;
#(
    parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic       maqc_clock,
    input  logic       maqc_reset,
    input  logic       maqc_btn_modo,
    input  logic       maqc_btn_inc,
    input  logic       maqc_seg_carry,
    input  logic       maqc_min_carry,
    output logic       maqc_seg_enable,
    output logic       maqc_seg_reset,
    output logic       maqc_inc_minuto,
    output logic       maqc_inc_hora,
    output logic [1:0] maqc_modo,
    output logic       maqc_pisca
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam int BW = $clog2(BLINK_DIV) + 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    modo_t         modo_q;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] blink_q;
    logic          pisca_q;
    logic          seg_reset_q;
    logic          ev_modo, ev_inc, inc_ok;
    logic          em_run, seg_en, inc_min_run;

    maq_botao u_botao_modo (
        .clock (maqc_clock),
        .reset (maqc_reset),
        .nivel (maqc_btn_modo),
        .pulso (ev_modo)
    );

    maq_botao u_botao_inc (
        .clock (maqc_clock),
        .reset (maqc_reset),
        .nivel (maqc_btn_inc),
        .pulso (ev_inc)
    );

    always_ff @(posedge maqc_clock) begin
        if (maqc_reset) begin
            modo_q      <= MODO_RUN;
            presc_q     <= '0;
            blink_q     <= '0;
            pisca_q     <= 1'b1;
            seg_reset_q <= 1'b0;
        end else begin
            seg_reset_q <= ev_modo && (modo_q == MODO_SET_MIN);

            case (modo_q)
                MODO_RUN:      if (ev_modo) modo_q <= MODO_SET_HORA;
                MODO_SET_HORA: if (ev_modo) modo_q <= MODO_SET_MIN;
                MODO_SET_MIN:  if (ev_modo) modo_q <= MODO_RUN;
                default:       modo_q <= MODO_RUN;
            endcase

            // Leaving RUN clears the prescaler so the next RUN interval starts a full second.
            if (modo_q == MODO_RUN && !ev_modo)
                presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
            else
                presc_q <= '0;

            // Any mode change restarts the blink with the field visible.
            if (modo_q == MODO_RUN || ev_modo) begin
                blink_q <= '0;
                pisca_q <= 1'b1;
            end else if (blink_q == BLINK_MAX) begin
                blink_q <= '0;
                pisca_q <= ~pisca_q;
            end else begin
                blink_q <= blink_q + BW'(1);
            end
        end
    end

    assign em_run      = (modo_q == MODO_RUN);
    assign inc_ok      = ev_inc && !ev_modo;
    assign seg_en      = !maqc_reset && em_run && (presc_q == PRESC_MAX);
    assign inc_min_run = seg_en && maqc_seg_carry;

    assign maqc_seg_enable = seg_en;
    assign maqc_seg_reset  = seg_reset_q && !maqc_reset;
    assign maqc_inc_minuto = em_run ? inc_min_run
                                    : (!maqc_reset && (modo_q == MODO_SET_MIN) && inc_ok);
    assign maqc_inc_hora   = em_run ? (inc_min_run && maqc_min_carry)
                                    : (!maqc_reset && (modo_q == MODO_SET_HORA) && inc_ok);
    assign maqc_modo       = modo_q;
    assign maqc_pisca      = pisca_q;

endmodule

// File: tb/tb_maq_ctrl.sv
// Bench for maq_ctrl: vector table, directed corner sequences and randomized run against a cycle model.
module tb_maq_ctrl;

    localparam int F = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bm = 1'b0, bi = 1'b0, sc = 1'b0, mc = 1'b0;
    logic       se, sr, im, ih, pisca;
    logic [1:0] modo;

    int checks = 0;
    int errors = 0;

    maq_ctrl #(.CLK_FREQ(F), .BLINK_DIV(B)) dut (
        .maqc_clock      (clk),
        .maqc_reset      (rst),
        .maqc_btn_modo   (bm),
        .maqc_btn_inc    (bi),
        .maqc_seg_carry  (sc),
        .maqc_min_carry  (mc),
        .maqc_seg_enable (se),
        .maqc_seg_reset  (sr),
        .maqc_inc_minuto (im),
        .maqc_inc_hora   (ih),
        .maqc_modo       (modo),
        .maqc_pisca      (pisca)
    );

    always #5 clk = ~clk;

    // Reference model: mode, cycles spent in the current RUN / SET interval, button level history.
    int m_mode = 0;
    int m_run  = 0;
    int m_set  = 0;
    bit m_sr   = 1'b0;
    bit hm[3]  = '{1'b0, 1'b0, 1'b0};
    bit hi[3]  = '{1'b0, 1'b0, 1'b0};
    bit m_em;

    always @(posedge clk) begin
        m_em = hm[1] && !hm[2];
        if (rst) begin
            m_mode = 0; m_run = 0; m_set = 0; m_sr = 1'b0;
            hm = '{1'b0, 1'b0, 1'b0};
            hi = '{1'b0, 1'b0, 1'b0};
        end else begin
            m_sr = (m_mode == 2) && m_em;
            if (m_em) begin
                m_mode = (m_mode + 1) % 3;
                m_run = 0;
                m_set = 0;
            end else if (m_mode == 0) begin
                m_run++;
            end else begin
                m_set++;
            end
            hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = bm;
            hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = bi;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_se, input logic e_im,
                              input logic e_ih, input logic e_sr,
                              input logic [1:0] e_modo, input logic e_pisca);
        chk({tag, ".seg_enable"}, 8'(se),    8'(e_se));
        chk({tag, ".inc_minuto"}, 8'(im),    8'(e_im));
        chk({tag, ".inc_hora"},   8'(ih),    8'(e_ih));
        chk({tag, ".seg_reset"},  8'(sr),    8'(e_sr));
        chk({tag, ".modo"},       8'(modo),  8'(e_modo));
        chk({tag, ".pisca"},      8'(pisca), 8'(e_pisca));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst, bm, bi, sc, mc;
        logic       se, im, ih, sr;
        logic [1:0] modo;
        logic       pisca;
    } vec_t;

    vec_t vt[37];

    initial begin
        logic e_se, e_im, e_ih, e_sr, e_pisca, e_em, e_ei;

        // Row 0 is a reset cycle; row r is cycle r-1 after reset release.
        for (int r = 0; r < 37; r++) begin
            vt[r] = '{default: 1'b0};
            vt[r].pisca = 1'b1;
        end
        vt[0].rst = 1'b1;
        vt[6].sc = 1'b1;
        vt[8].sc = 1'b1; vt[8].mc = 1'b1;
        vt[8].se = 1'b1; vt[8].im = 1'b1; vt[8].ih = 1'b1;
        for (int c = 10; c <= 14; c++) vt[c+1].bm = 1'b1;
        for (int c = 13; c <= 28; c++) begin
            vt[c+1].modo  = 2'd1;
            vt[c+1].pisca = (((c - 13) / 2) % 2) == 0;
        end
        for (int c = 20; c <= 22; c++) vt[c+1].bi = 1'b1;
        vt[23].ih = 1'b1;
        vt[27].bm = 1'b1;
        for (int c = 29; c <= 35; c++) begin
            vt[c+1].modo  = 2'd2;
            vt[c+1].pisca = (((c - 29) / 2) % 2) == 0;
        end
        vt[32].bi = 1'b1;
        vt[34].im = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 37; r++) begin
            rst = vt[r].rst; bm = vt[r].bm; bi = vt[r].bi; sc = vt[r].sc; mc = vt[r].mc;
            @(negedge clk);
            check_outs($sformatf("vec%0d", r), vt[r].se, vt[r].im, vt[r].ih,
                       vt[r].sr, vt[r].modo, vt[r].pisca);
            step();
        end
        rst = 1'b0; bm = 1'b0; bi = 1'b0; sc = 1'b0; mc = 1'b0;

        // SET_MIN -> RUN: seg_reset on the first RUN cycle, full second afterwards.
        bm = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("exit.modo%0d", k),   8'(modo), (k >= 3) ? 8'd0 : 8'd2);
            chk($sformatf("exit.segrst%0d", k), 8'(sr),   8'(k == 3));
            chk($sformatf("exit.segen%0d", k),  8'(se),   8'(k == 10));
            step();
            bm = 1'b0;
        end

        // inc press in RUN is ignored.
        bi = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("runinc.min%0d", k),  8'(im), 8'd0);
            chk($sformatf("runinc.hora%0d", k), 8'(ih), 8'd0);
            step();
            bi = 1'b0;
        end

        // Walk to SET_MIN, then press both buttons together.
        for (int p = 0; p < 2; p++) begin
            bm = 1'b1;
            step();
            bm = 1'b0;
            repeat (5) step();
        end
        @(negedge clk);
        chk("setmin.modo", 8'(modo), 8'd2);
        step();
        bm = 1'b1; bi = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("both.min%0d", k),  8'(im),   8'd0);
            chk($sformatf("both.modo%0d", k), 8'(modo), (k >= 3) ? 8'd0 : 8'd2);
            step();
            bm = 1'b0; bi = 1'b0;
        end

        // Reset while SET_HORA has the field blanked.
        bm = 1'b1;
        step();
        bm = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        check_outs("midrst.in", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        step();
        rst = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            check_outs($sformatf("midrst.c%0d", j), j == 7, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
            step();
        end

        // Mode button held through reset release gives exactly one edge.
        rst = 1'b1; bm = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            chk($sformatf("held.modo%0d", j), 8'(modo), (j >= 3) ? 8'd1 : 8'd0);
            step();
        end
        bm = 1'b0;

        // Randomized traffic compared against the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(11) == 0) bm = ~bm;
            if ($urandom_range(7) == 0)  bi = ~bi;
            sc  = ($urandom_range(2) == 0);
            mc  = 1'($urandom_range(1));
            rst = ($urandom_range(299) == 0);
            @(negedge clk);
            e_em    = hm[1] && !hm[2];
            e_ei    = hi[1] && !hi[2];
            e_se    = !rst && (m_mode == 0) && ((m_run % F) == F - 1);
            e_im    = (m_mode == 0) ? (e_se && sc) : (!rst && (m_mode == 2) && e_ei && !e_em);
            e_ih    = (m_mode == 0) ? (e_se && sc && mc) : (!rst && (m_mode == 1) && e_ei && !e_em);
            e_sr    = !rst && m_sr;
            e_pisca = (m_mode == 0) ? 1'b1 : (((m_set / B) % 2) == 0);
            check_outs("rnd", e_se, e_im, e_ih, e_sr, 2'(m_mode), e_pisca);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
